// File: rtl/ifu_npc.sv
// ifu_npc: instruction fetch unit for the single-cycle MIPS datapath.
// Holds the PC, fetches over a req/ack handshake, holds the instruction
// until the core reports completion, then selects the next PC.
// Optional macro IFU_JR_EN adds rs_data and makes npcctr = 11 a jr.
//
// Handshakes: imem_req is a registered request that stays high in FETCH
// until an edge with imem_ack = 1 (imem_rdata is captured on that edge).
// instr_valid stays high in HOLD until an edge with instr_done = 1
// (npcctr is sampled on that edge). Acks outside FETCH and dones outside
// HOLD are ignored.
module ifu_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_done,
    input  logic [1:0]       npcctr,
`ifdef IFU_JR_EN
    input  logic [31:0]      rs_data,
`endif
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired,
    output logic             npc_err
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               imem_req_q, imem_req_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               npc_err_q, npc_err_d;
    logic [31:0]        npc;
    logic               npc_bad;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC mux from the held instruction and the control unit's select.
    always_comb begin
        npc     = pc_plus4;
        npc_bad = 1'b0;
        case (npcctr)
            2'b01:   npc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
            2'b10:   npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            2'b11: begin
`ifdef IFU_JR_EN
                npc = rs_data & 32'hFFFF_FFFC;
`else
                npc     = pc_plus4;
                npc_bad = 1'b1;
`endif
            end
            default: npc = pc_plus4;
        endcase
    end

    // Fetch/hold sequencing and next values of all architectural state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        retired_d     = retired_q;
        npc_err_d     = npc_err_q;
        case (state_q)
            RST_WAIT: begin
                // A stale ack from a fetch cut short by reset lands here and is dropped.
                imem_req_d = 1'b1;
                state_d    = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (instr_done) begin
                    pc_d          = npc;
                    retired_d     = retired_q + CNT_W'(1);
                    npc_err_d     = npc_err_q | npc_bad;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    state_d       = FETCH;
                end
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = RST_WAIT;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_WAIT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            retired_q     <= '0;
            npc_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            retired_q     <= retired_d;
            npc_err_q     <= npc_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign npc_err     = npc_err_q;

endmodule

// File: doc/ifu_npc.md
Name: ifu_npc

Overview:
- Instruction fetch unit with PC register and next-PC selection for the single-cycle MIPS datapath.
- Fetches the instruction at `pc` from instruction memory using a req/ack handshake.
- Presents the instruction to the decode/control stage and holds it until the core signals completion.
- On completion, updates `pc` from the control unit's `npcctr` (00 sequential, 01 taken branch, 10 jump).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 00.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals `pc`.
- imem_ack  input  1  memory response valid; `imem_rdata` is sampled on the same edge.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  held instruction to decode (op = [31:26], func = [5:0]).
- instr_valid  output  1  `instr` is valid and being executed.
- instr_done  input  1  core finished executing `instr`; `npcctr` is sampled this edge.
- npcctr  input  2  next-PC select from control unit.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  `pc` + 4, for link use.
- retired  output  CNT_W  count of completed instructions.
- npc_err  output  1  sticky flag set when an unsupported `npcctr` value is used.

Behaviour:
- Reset (async) values:
  - `pc` = RESET_PC.
  - `instr` = 0, `instr_valid` = 0, `imem_req` = 0.
  - `retired` = 0, `npc_err` = 0.
  - state = RST_WAIT.
- States: RST_WAIT, FETCH, HOLD.
- RST_WAIT:
  - `imem_req` = 0; `imem_ack` is ignored (discards a stale response from a fetch interrupted by reset).
  - Always goes to FETCH on the next edge.
- FETCH:
  - `imem_req` = 1 (registered output, asserted from the first FETCH cycle).
  - On an edge with `imem_ack` = 1: capture `instr` <= `imem_rdata`, `instr_valid` <= 1, `imem_req` <= 0, go to HOLD.
  - Minimum latency: FETCH entry to `instr_valid` high = 1 cycle if ack is already high; no timeout.
- HOLD:
  - `instr` is stable and `imem_req` = 0.
  - On an edge with `instr_done` = 1:
    - `pc` <= npc, `retired` <= `retired` + 1.
    - `instr_valid` <= 0; go to FETCH.
  - `instr` keeps its old value until the next ack.
- `instr_done` outside HOLD: ignored. `imem_ack` outside FETCH: ignored.
- npc computation (combinational from `pc`, `instr`, `npcctr`):
  - 00: `pc_plus4`.
  - 01: `pc_plus4` + (sign-extended `instr[15:0]` << 2).
  - 10: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - 11: `pc_plus4`, and `npc_err` <= 1 (see optional feature).
- Arithmetic is modulo 2^32: PC 32'hFFFF_FFFC + 4 wraps to 0, and branch overflow wraps silently.
- npc[1:0] is always 00.
- `retired` wraps at 2^CNT_W.
- `npc_err` is cleared only by reset.
- Reset asserted mid-FETCH or mid-HOLD: all state returns to reset values immediately; the outstanding ack is dropped via RST_WAIT.

Optional Feature:
- Macro: IFU_JR_EN.
- Defined:
  - Adds input port `rs_data[31:0]`.
  - `npcctr` = 11 selects npc = {`rs_data[31:2]`, 2'b00} (jr) and does not set `npc_err`.
- Undefined:
  - No `rs_data` port.
  - `npcctr` = 11 behaves as sequential (`pc_plus4`) and sets `npc_err`.

Test Plan:
- Reset sequence: assert `reset`, release; hold ack = 1 constantly -> `imem_req` stays 0 for the RST_WAIT cycle, then `imem_addr` = 32'h0000_3000; `instr_valid` rises one edge after `imem_req`.
- Sequential flow: three instructions, each with ack after 2 wait cycles and `npcctr` = 00 -> fetch addresses 3000, 3004, 3008; `retired` = 3.
- Branch:
  - `pc` = 32'h3010, `instr[15:0]` = 16'hFFFE, `npcctr` = 01 -> next `pc` = 32'h300C.
  - `instr[15:0]` = 16'h0003 -> next `pc` = 32'h3020.
- Jump: `pc` = 32'h3000, `instr[25:0]` = 26'h0000C05, `npcctr` = 10 -> next `pc` = 32'h0000_3014.
- Reset mid-FETCH: reset asserted while `imem_req` = 1, ack arrives during RST_WAIT -> ack ignored, `instr_valid` = 0, and the refetch is at RESET_PC.
- `npcctr` = 11 with `rs_data` = 32'h0000_4007:
  - With IFU_JR_EN: `pc` = 32'h4004, `npc_err` = 0.
  - Without IFU_JR_EN: `pc` = `pc_plus4`, `npc_err` = 1 and stays 1.
